// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: enable levels, register-number
// width and the load-buffer entry layout.
package writeback_unit_pkg;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;
    localparam int ENTRY_W  = REG_W + DATA_W;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// Load-result buffer: a power-of-two FIFO with a registered occupancy count.
// Pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: single-cycle ALU results take the write port
// first, buffered load results fill idle slots; a scoreboard tracks pending writes.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [REG_W-1:0]    alu_dst,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_W-1:0]    mem_dst,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_dst,
    output logic                reg_we,
    output logic [REG_W-1:0]    dstreg_num,
    output logic [DATA_W-1:0]   dstreg_data,
    output logic [NUM_REGS-1:0] pending
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t         push_entry;
    wb_entry_t         head_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] pending_next;

    // Load handshake: a transfer happens on an edge where mem_valid && mem_ready.
    // mem_ready depends only on the registered count, so a full buffer refuses
    // even when the same edge pops an entry.
    assign mem_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_push  = mem_valid && mem_ready && (mem_dst != '0);
    assign fifo_pop   = !alu_valid && !fifo_empty;
    assign push_entry = '{dst: mem_dst, data: mem_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // An ALU write to r0 still owns the slot, so the buffer waits a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we      <= DISABLE;
            dstreg_num  <= '0;
            dstreg_data <= '0;
        end else if (alu_valid) begin
            reg_we      <= (alu_dst != '0) ? ENABLE : DISABLE;
            dstreg_num  <= alu_dst;
            dstreg_data <= alu_data;
        end else if (!fifo_empty) begin
            reg_we      <= ENABLE;
            dstreg_num  <= head_entry.dst;
            dstreg_data <= head_entry.data;
        end else begin
            reg_we      <= DISABLE;
        end
    end

    // A new claim wins over a retiring write to the same register.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid) begin
            set_mask[issue_dst] = 1'b1;
        end
        if (reg_we == ENABLE) begin
            clr_mask[dstreg_num] = 1'b1;
        end
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (FIFO_DEPTH = 4).
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dst;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        reg_we;
    logic [4:0]  dstreg_num;
    logic [31:0] dstreg_data;
    logic [31:0] pending;

    int checks;
    int errors;

    logic [36:0] exp_q[$];

    writeback_unit #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_dst     (alu_dst),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_dst     (mem_dst),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .reg_we      (reg_we),
        .dstreg_num  (dstreg_num),
        .dstreg_data (dstreg_data),
        .pending     (pending)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: inputs change at negedge, outputs are checked at negedge
    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_dst     = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_dst     = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_dst   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (reg_we !== 1'b0 || dstreg_num !== 5'd0 || dstreg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b num=%0d data=%h, required 0/0/0", reg_we, dstreg_num, dstreg_data);
        end
        checks++;
        if (mem_ready !== 1'b1 || pending !== 32'd0) begin
            errors++;
            $display("FAIL reset_ready_pending: ready=%b pending=%h, required 1/0", mem_ready, pending);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'h1234;
        step();
        alu_valid = 1'b0;
        checks++;
        if (reg_we !== 1'b1 || dstreg_num !== 5'd5 || dstreg_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_write: we=%b num=%0d data=%h, required 1/5/00001234", reg_we, dstreg_num, dstreg_data);
        end
        step();
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_one_cycle: we=%b, required 0", reg_we);
        end
        alu_valid = 1'b1; alu_dst = 5'd0; alu_data = 32'h55;
        step();
        alu_valid = 1'b0;
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_r0: we=%b, required 0", reg_we);
        end
        step();
    endtask

    task automatic test_contention();
        mem_valid = 1'b1; mem_dst = 5'd3; mem_data = 32'hAA;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL cont_ready: ready=%b, required 1", mem_ready);
        end
        step();
        mem_valid = 1'b0;
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL cont_no_bypass: we=%b, required 0", reg_we);
        end
        alu_valid = 1'b1; alu_dst = 5'd4; alu_data = 32'h11;
        step();
        checks++;
        if (reg_we !== 1'b1 || dstreg_num !== 5'd4 || dstreg_data !== 32'h11) begin
            errors++;
            $display("FAIL cont_alu1: we=%b num=%0d data=%h, required 1/4/00000011", reg_we, dstreg_num, dstreg_data);
        end
        alu_data = 32'h22;
        step();
        alu_valid = 1'b0;
        checks++;
        if (reg_we !== 1'b1 || dstreg_num !== 5'd4 || dstreg_data !== 32'h22) begin
            errors++;
            $display("FAIL cont_alu2: we=%b num=%0d data=%h, required 1/4/00000022", reg_we, dstreg_num, dstreg_data);
        end
        step();
        checks++;
        if (reg_we !== 1'b1 || dstreg_num !== 5'd3 || dstreg_data !== 32'hAA) begin
            errors++;
            $display("FAIL cont_load: we=%b num=%0d data=%h, required 1/3/000000aa", reg_we, dstreg_num, dstreg_data);
        end
        step();
        checks++;
        if (reg_we !== 1'b0) begin
            errors++;
            $display("FAIL cont_idle: we=%b, required 0", reg_we);
        end
    endtask

    task automatic test_full();
        int          cnt;
        int          idx;
        bit          accept;
        bit          do_pop;
        logic [36:0] exp_e;
        cnt = 0;
        idx = 0;
        exp_q.delete();
        alu_valid = 1'b1;
        alu_dst   = 5'd1;
        for (int c = 0; c < 5; c++) begin
            alu_data  = 32'(c);
            mem_valid = 1'b1;
            mem_dst   = 5'(10 + idx);
            mem_data  = 32'h100 + 32'(idx);
            checks++;
            if (mem_ready !== (cnt != 4)) begin
                errors++;
                $display("FAIL full_ready_fill c=%0d: ready=%b, required %b", c, mem_ready, (cnt != 4));
            end
            accept = (cnt != 4);
            step();
            if (accept) begin
                exp_q.push_back({mem_dst, mem_data});
                idx++;
                cnt++;
            end
            checks++;
            if (reg_we !== 1'b1 || dstreg_num !== 5'd1 || dstreg_data !== 32'(c)) begin
                errors++;
                $display("FAIL full_alu c=%0d: we=%b num=%0d data=%h, required 1/1/%h", c, reg_we, dstreg_num, dstreg_data, 32'(c));
            end
        end
        alu_valid = 1'b0;
        for (int c = 0; c < 12 && (cnt != 0 || idx != 5); c++) begin
            mem_valid = (idx < 5);
            mem_dst   = 5'(10 + idx);
            mem_data  = 32'h100 + 32'(idx);
            if (mem_valid) begin
                checks++;
                if (mem_ready !== (cnt != 4)) begin
                    errors++;
                    $display("FAIL full_ready_drain c=%0d: ready=%b, required %b", c, mem_ready, (cnt != 4));
                end
            end
            accept = mem_valid && (cnt != 4);
            do_pop = (cnt > 0);
            exp_e  = '0;
            if (do_pop) exp_e = exp_q.pop_front();
            if (accept) exp_q.push_back({mem_dst, mem_data});
            step();
            if (accept) idx++;
            cnt = cnt + int'(accept) - int'(do_pop);
            checks++;
            if (reg_we !== do_pop || (do_pop && {dstreg_num, dstreg_data} !== exp_e)) begin
                errors++;
                $display("FAIL full_drain c=%0d: we=%b num=%0d data=%h, required %b/%0d/%h", c, reg_we, dstreg_num, dstreg_data, do_pop, exp_e[36:32], exp_e[31:0]);
            end
        end
        mem_valid = 1'b0;
        checks++;
        if (idx != 5 || cnt != 0) begin
            errors++;
            $display("FAIL full_fifth_accepted: accepted=%0d left=%0d, required 5/0", idx, cnt);
        end
        step();
        checks++;
        if (reg_we !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_empty_after: we=%b ready=%b, required 0/1", reg_we, mem_ready);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_dst = 5'd7;
        step();
        issue_valid = 1'b0;
        checks++;
        if (pending !== 32'h80) begin
            errors++;
            $display("FAIL sb_set: pending=%h, required 00000080", pending);
        end
        mem_valid = 1'b1; mem_dst = 5'd7; mem_data = 32'h77;
        step();
        mem_valid = 1'b0;
        step();
        checks++;
        if (reg_we !== 1'b1 || dstreg_num !== 5'd7 || pending !== 32'h80) begin
            errors++;
            $display("FAIL sb_write: we=%b num=%0d pending=%h, required 1/7/00000080", reg_we, dstreg_num, pending);
        end
        step();
        checks++;
        if (pending !== 32'h0) begin
            errors++;
            $display("FAIL sb_clear: pending=%h, required 00000000", pending);
        end
        issue_valid = 1'b1; issue_dst = 5'd7;
        mem_valid = 1'b1; mem_dst = 5'd7; mem_data = 32'h78;
        step();
        issue_valid = 1'b0;
        mem_valid = 1'b0;
        step();
        // write-back of r7 is on the outputs; re-issue r7 on the edge that retires it
        issue_valid = 1'b1; issue_dst = 5'd7;
        step();
        issue_valid = 1'b0;
        checks++;
        if (pending !== 32'h80) begin
            errors++;
            $display("FAIL sb_set_wins: pending=%h, required 00000080", pending);
        end
        issue_valid = 1'b1; issue_dst = 5'd0;
        step();
        issue_valid = 1'b0;
        checks++;
        if (pending !== 32'h80) begin
            errors++;
            $display("FAIL sb_r0: pending=%h, required 00000080", pending);
        end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_dst = 5'd2; alu_data = 32'h5;
        issue_valid = 1'b1; issue_dst = 5'd9;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1;
            mem_dst   = 5'(20 + i);
            mem_data  = 32'h300 + 32'(i);
            step();
            issue_valid = 1'b0;
        end
        idle_inputs();
        checks++;
        if (reg_we !== 1'b1 || pending[9] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: we=%b pending9=%b, required 1/1", reg_we, pending[9]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (reg_we !== 1'b0 || dstreg_num !== 5'd0 || dstreg_data !== 32'd0 || pending !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: we=%b num=%0d data=%h pending=%h, required all 0", reg_we, dstreg_num, dstreg_data, pending);
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: ready=%b, required 1", mem_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (reg_we !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard cycle %0d: we=%b num=%0d, required we 0", i, reg_we, dstreg_num);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_only();
        test_contention();
        test_full();
        test_scoreboard();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the load-result buffer depth (power of 2, 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 alu_valid  input  1  SHALL flag a single-cycle ALU result this cycle.
REQ-005 alu_dst  input  5  SHALL carry the ALU destination register number.
REQ-006 alu_data  input  32  SHALL carry the ALU result.
REQ-007 mem_valid  input  1  SHALL flag a load result offered by the memory stage.
REQ-008 mem_ready  output  1  SHALL indicate a load result is accepted this cycle.
REQ-009 mem_dst  input  5  SHALL carry the load destination register number.
REQ-010 mem_data  input  32  SHALL carry the load data.
REQ-011 issue_valid  input  1  SHALL flag an instruction issue that claims a destination.
REQ-012 issue_dst  input  5  SHALL carry the claimed destination register number.
REQ-013 reg_we  output  1  SHALL be the register file write enable (ENABLE = 1).
REQ-014 dstreg_num  output  5  SHALL be the register file write address.
REQ-015 dstreg_data  output  32  SHALL be the register file write data.
REQ-016 pending  output  32  SHALL be the scoreboard, one bit per register, 1 = write outstanding.

Function
REQ-017 reg_we, dstreg_num, dstreg_data SHALL be registered; every write appears exactly one cycle after its selecting edge and lasts one cycle.
REQ-018 At each edge: if alu_valid, output <= ALU result; else if FIFO non-empty, output <= FIFO head and head is popped; else reg_we <= 0.
REQ-019 ALU results SHALL never be buffered or stalled; ALU has strict priority over the FIFO.
REQ-020 mem_ready SHALL equal (count != FIFO_DEPTH), combinational from registered count only; a handshake occurs when mem_valid && mem_ready.
REQ-021 When full, mem_ready SHALL be 0 even if a pop occurs in the same cycle (no full-bypass).
REQ-022 Simultaneous push and pop SHALL leave count unchanged; no push-to-output bypass (minimum load latency: 2 edges from handshake to reg_we).
REQ-023 FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-024 An ALU result with alu_dst = 0 SHALL consume the write slot with reg_we = 0 and no FIFO pop.
REQ-025 A handshaken load with mem_dst = 0 SHALL be accepted and discarded (not stored).
REQ-026 pending[n] SHALL set on issue_valid && issue_dst == n (n != 0) and clear when reg_we is driven 1 with dstreg_num == n.
REQ-027 Same-edge set and clear of one bit SHALL leave it set; pending[0] SHALL always be 0.

Reset
REQ-028 rst SHALL immediately force reg_we = 0, dstreg_num = 0, dstreg_data = 0, pending = 0, count = 0, pointers = 0, mem_ready = 1.
REQ-029 Reset mid-operation SHALL discard all buffered loads; FIFO storage contents need not be cleared.

Structure
REQ-030 ENABLE/DISABLE constants and register-number width SHALL come from the shared define file.
REQ-031 The load buffer SHALL be one sub-module, wb_fifo (parameterised depth, 37-bit entries).

Verification
REQ-032 ALU only: alu_valid, dst 5, data 0x1234 -> next cycle reg_we = 1, dstreg_num = 5, dstreg_data = 0x1234.
REQ-033 Contention: load dst 3 0xAA handshaken, then alu_valid dst 4 for 2 cycles -> writes r4, r4, then r3 = 0xAA.
REQ-034 Full: alu_valid held, 5 loads offered (depth 4) -> mem_ready = 0 after 4 accepts; drop alu_valid -> drained in order, 5th accepted once not full.
REQ-035 Scoreboard: issue dst 7 -> pending[7] = 1; load r7 written -> pending[7] = 0; issue dst 7 on write-back edge -> stays 1; issue dst 0 -> pending[0] = 0.
REQ-036 Reset: assert rst with 3 buffered loads -> outputs 0 asynchronously, no writes after release, mem_ready = 1.
